// File: rtl/tessiax_pkg.sv
// rtl/tessiax_pkg.sv - shared types and constants for the TessiaX hazard controller
// Purpose : forwarding-select and multiply-FSM enums, ALU/regfile constants.
// Contents: fwd_sel_t, mul_state_t, ALU_MUL, REG_PC.
package tessiax_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } mul_state_t;

  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] REG_PC  = 4'hF;

endpackage

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - multi-cycle multiply hold sequencer for the EX stage
// Purpose : holds a multiply in EX for exactly MUL_CYCLES cycles.
// Ports   : clk, reset (async, active-high), MulStartE (valid multiply in E)
//           MulStall (hold EX this cycle), MulBusy (FSM in MUL),
//           MulDoneE (final EX cycle of the multiply).
module mul_sequencer
  import tessiax_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic MulStartE,
  output logic MulStall,
  output logic MulBusy,
  output logic MulDoneE
);

  // A single-cycle multiply needs no hold, so the FSM stays in IDLE.
  localparam bit         MULTI    = (MUL_CYCLES > 1);
  localparam logic [3:0] CNT_INIT = MULTI ? 4'(MUL_CYCLES - 2) : 4'd0;

  mul_state_t state;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (MulStartE && MULTI) begin
            state <= MUL;
            cnt   <= CNT_INIT;
          end
        end
        MUL: begin
          // MulStartE is ignored here: E still holds the same multiply.
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The IDLE cycle that accepts the multiply counts as its first EX cycle,
  // so MUL only needs MUL_CYCLES-1 further cycles (Cnt from MUL_CYCLES-2 to 0).
  always_comb begin
    MulBusy  = (state == MUL);
    MulStall = 1'b0;
    MulDoneE = 1'b0;
    if (state == MUL) begin
      MulStall = (cnt != 4'd0);
      MulDoneE = (cnt == 4'd0);
    end else begin
      MulStall = MulStartE && MULTI;
      MulDoneE = MulStartE && !MULTI;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - forwarding, load-use, flush and multiply-hold control
// Purpose : drives EX operand forwarding selects and the stall/flush enables
//           of every TessiaX pipeline register.
// Ports   : in  RA1D/RA2D, RA1E/RA2E, WA3E/WA3M/WA3W, RegWriteE/M/W, MemToRegE,
//               PCWrPendingF, PCSrcW, BranchTakenE, MulStartE, clk, reset
//           out ForwardAE/BE, StallF/D/E, FlushD/E/M, MulBusy, MulDoneE
module pipeline_hazard_ctrl
  import tessiax_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int REG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] RA1E,
  input  logic [REG_W-1:0] RA2E,
  input  logic [REG_W-1:0] WA3E,
  input  logic [REG_W-1:0] WA3M,
  input  logic [REG_W-1:0] WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             PCWrPendingF,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MulStartE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MulBusy,
  output logic             MulDoneE
);

  localparam logic [REG_W-1:0] PC_ADDR = REG_W'(REG_PC);

  // PC reads come from the fetch path, never from a forwarded result.
  function automatic fwd_sel_t fwd_sel(input logic [REG_W-1:0] src);
    if (src == PC_ADDR)                  return FWD_RF;
    else if (RegWriteM && WA3M == src)   return FWD_MEM;
    else if (RegWriteW && WA3W == src)   return FWD_WB;
    else                                 return FWD_RF;
  endfunction

  logic ldr_stall;
  logic mul_stall;

  mul_sequencer #(
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul_sequencer (
    .clk      (clk),
    .reset    (reset),
    .MulStartE(MulStartE),
    .MulStall (mul_stall),
    .MulBusy  (MulBusy),
    .MulDoneE (MulDoneE)
  );

  always_comb begin
    ForwardAE = fwd_sel(RA1E);
    ForwardBE = fwd_sel(RA2E);
    ldr_stall = MemToRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));

    StallF = ldr_stall | PCWrPendingF | mul_stall;
    StallD = ldr_stall | mul_stall;
    StallE = mul_stall;
    FlushM = mul_stall;

    // A stalled stage must keep its contents, so stalls mask flushes.
    FlushD = (PCWrPendingF | PCSrcW | BranchTakenE) & ~StallD;
    FlushE = (ldr_stall | BranchTakenE) & ~StallE;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - randomized self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE;
  logic       PCWrPendingF, PCSrcW, BranchTakenE, MulStartE;

  // instance a: MUL_CYCLES=4, instance b: MUL_CYCLES=1
  logic [1:0] a_fa, a_fb, b_fa, b_fb;
  logic a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_mb, a_md;
  logic b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_mb, b_md;

  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .REG_W(4)) dut_a (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .ForwardAE(a_fa), .ForwardBE(a_fb),
    .StallF(a_sf), .StallD(a_sd), .StallE(a_se),
    .FlushD(a_fd), .FlushE(a_fe), .FlushM(a_fm),
    .MulBusy(a_mb), .MulDoneE(a_md)
  );

  pipeline_hazard_ctrl #(.MUL_CYCLES(1), .REG_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .ForwardAE(b_fa), .ForwardBE(b_fb),
    .StallF(b_sf), .StallD(b_sd), .StallE(b_se),
    .FlushD(b_fd), .FlushE(b_fe), .FlushM(b_fm),
    .MulBusy(b_mb), .MulDoneE(b_md)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a multiply occupies EX for N consecutive cycles; phase
  // counts how many of those cycles are already behind us.
  bit a_inmul, b_inmul;
  int a_phase, b_phase;

  function automatic logic [1:0] ref_fwd(input logic [3:0] src);
    if (src == 4'd15)                  return 2'b00;
    if (RegWriteM && WA3M == src)      return 2'b10;
    if (RegWriteW && WA3W == src)      return 2'b01;
    return 2'b00;
  endfunction

  // Returns {StallF,StallD,StallE,FlushD,FlushE,FlushM,MulBusy,MulDoneE}
  function automatic logic [7:0] ref_ctl(input int n, input bit inmul, input int phase);
    bit active, ldr, ms, sf, sd, se, fd, fe, md;
    int k;
    active = inmul || MulStartE;
    k      = inmul ? phase : 0;
    ms     = active && (k < n - 1);
    md     = active && (k == n - 1);
    ldr    = MemToRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D);
    sf     = ldr || PCWrPendingF || ms;
    sd     = ldr || ms;
    se     = ms;
    fd     = (PCWrPendingF || PCSrcW || BranchTakenE) && !sd;
    fe     = (ldr || BranchTakenE) && !se;
    return {sf, sd, se, fd, fe, ms, inmul, md};
  endfunction

  task automatic advance(input int n, inout bit inmul, inout int phase);
    int k;
    if (inmul || MulStartE) begin
      k = inmul ? phase : 0;
      if (k < n - 1) begin
        inmul = 1'b1;
        phase = k + 1;
      end else begin
        inmul = 1'b0;
        phase = 0;
      end
    end
  endtask

  task automatic check_all();
    #2;
    chk("a_fwd", {a_fa, a_fb}, {ref_fwd(RA1E), ref_fwd(RA2E)});
    chk("a_ctl", {a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_mb, a_md}, ref_ctl(4, a_inmul, a_phase));
    chk("b_fwd", {b_fa, b_fb}, {ref_fwd(RA1E), ref_fwd(RA2E)});
    chk("b_ctl", {b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_mb, b_md}, ref_ctl(1, b_inmul, b_phase));
  endtask

  task automatic tick();
    @(posedge clk);
    advance(4, a_inmul, a_phase);
    advance(1, b_inmul, b_phase);
    #1;
  endtask

  task automatic clear_inputs();
    {RA1D, RA2D, RA1E, RA2E} = '0;
    WA3E = 4'd9; WA3M = 4'd10; WA3W = 4'd11;
    {RegWriteE, RegWriteM, RegWriteW, MemToRegE} = '0;
    {PCWrPendingF, PCSrcW, BranchTakenE, MulStartE} = '0;
  endtask

  function automatic logic [3:0] rnd_addr();
    if ($urandom_range(0, 4) == 0) return 4'd15;
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin
    reset = 1'b1;
    clear_inputs();
    a_inmul = 0; a_phase = 0; b_inmul = 0; b_phase = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    check_all();
    chk("rst_busy", {a_mb, b_mb}, 2'b00);
    chk("rst_done", {a_md, b_md}, 2'b00);
    tick();

    // forwarding priority and R15 exclusion
    RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3;
    check_all(); chk("fwd_mem", a_fa, 2'b10); tick();
    RegWriteM = 0;
    check_all(); chk("fwd_wb", a_fa, 2'b01); tick();
    RegWriteM = 1; RA1E = 15; WA3M = 15; WA3W = 15;
    check_all(); chk("fwd_pc", a_fa, 2'b00); tick();
    clear_inputs();

    // load-use
    MemToRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5;
    check_all(); chk("ldr_on", {a_sf, a_sd, a_fe, a_se}, 4'b1110); tick();
    RA2D = 6;
    check_all(); chk("ldr_off", {a_sf, a_sd, a_fe, a_se}, 4'b0000); tick();
    clear_inputs();

    // multiply: 4-cycle on instance a, single-cycle on instance b
    MulStartE = 1;
    check_all(); chk("mul_c0", {a_se, a_fm, a_mb}, 3'b110);
    chk("mul1_c0", {b_md, b_se, b_mb}, 3'b100); tick();
    check_all(); chk("mul_c1", {a_se, a_fm, a_mb}, 3'b111); tick();
    MulStartE = 0; BranchTakenE = 1;
    check_all(); chk("br_mul", {a_fe, a_se}, 2'b01); tick();
    BranchTakenE = 0;
    check_all(); chk("mul_c3", {a_md, a_se, a_mb}, 3'b101); tick();
    check_all(); chk("mul_c4", {a_md, a_se, a_mb}, 3'b000); tick();

    // branch in IDLE
    BranchTakenE = 1;
    check_all(); chk("br_idle", {a_fd, a_fe, a_se}, 3'b110); tick();
    clear_inputs();

    // async reset in cycle 1 of a multiply
    MulStartE = 1;
    check_all(); tick();
    MulStartE = 0;
    check_all(); chk("pre_rst", a_mb, 1'b1);
    reset = 1'b1;
    #1;
    a_inmul = 0; a_phase = 0; b_inmul = 0; b_phase = 0;
    chk("async_rst", {a_mb, a_se}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;
    check_all(); chk("post_rst", {a_sf, a_sd, a_se}, 3'b000); tick();

    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      RA1D = rnd_addr(); RA2D = rnd_addr(); RA1E = rnd_addr(); RA2E = rnd_addr();
      WA3E = rnd_addr(); WA3M = rnd_addr(); WA3W = rnd_addr();
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemToRegE = ($urandom_range(0, 3) == 0);
      PCWrPendingF = ($urandom_range(0, 5) == 0);
      PCSrcW = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      MulStartE = ($urandom_range(0, 4) == 0);
      check_all();
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b1;
        #1;
        a_inmul = 0; a_phase = 0; b_inmul = 0; b_phase = 0;
        chk("rnd_rst", {a_mb, a_md && !MulStartE}, 2'b00);
        check_all();
        reset = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage TessiaX pipeline (F/D/E/M/W). It produces operand forwarding selects for EX and detects load-use hazards. It handles PC-write and branch flushes, and holds EX for multi-cycle multiplies (ALUControl 4'b0010) through a small FSM and counter. It sits beside the decode control unit and drives the stall/flush enables of every pipeline register.

Parameters:
MUL_CYCLES, 4, total cycles a multiply occupies EX (legal range 1..15; 1 means no stall)
REG_W, 4, register address width

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
RA1D, RA2D  in  REG_W  source register addresses in D
RA1E, RA2E  in  REG_W  source register addresses in E
WA3E, WA3M, WA3W  in  REG_W  destination register addresses in E/M/W
RegWriteE, RegWriteM, RegWriteW  in  1  register-write enable per stage
MemToRegE  in  1  instruction in E is a load
PCWrPendingF  in  1  PCSrcD|PCSrcE|PCSrcM
PCSrcW  in  1  PC-writing instruction in W
BranchTakenE  in  1  branch resolved taken in E
MulStartE  in  1  valid multiply present in E
ForwardAE, ForwardBE  out  2  EX operand select: 00 register file, 01 W result, 10 M ALU result
StallF, StallD, StallE  out  1  hold the F/D/E pipeline registers
FlushD, FlushE, FlushM  out  1  bubble the D/E/M pipeline registers
MulBusy  out  1  multiply FSM is in MUL
MulDoneE  out  1  final EX cycle of a multiply

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high. Reset forces state IDLE and Cnt=0, which gives MulBusy=0 and MulDoneE=0. All other outputs are combinational functions of the inputs and state, with no flops.
- Forwarding, per operand X in {A,B} with source RA1E/RA2E:
  - 10 if RegWriteM and WA3M matches the source.
  - else 01 if RegWriteW and WA3W matches the source.
  - else 00.
  - M has priority over W. R15 is never forwarded: address 4'hF always yields 00.
- Load-use: LdrStall = MemToRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D).
- Multiply FSM, states IDLE and MUL; Cnt is a 4-bit down-counter.
  - IDLE with MulStartE and MUL_CYCLES>1: MulStall=1; next state MUL; Cnt<=MUL_CYCLES-2.
  - MUL with Cnt!=0: MulStall=1; Cnt decrements.
  - MUL with Cnt==0: MulStall=0; MulDoneE=1; next state IDLE. The instruction leaves E on this edge.
  - MUL_CYCLES==1: the FSM never leaves IDLE; MulDoneE=MulStartE.
  - Result: EX is held for exactly MUL_CYCLES cycles per multiply. MulStartE staying high during MUL is ignored.
- Stall outputs:
  - StallF = LdrStall | PCWrPendingF | MulStall.
  - StallD = LdrStall | MulStall.
  - StallE = MulStall.
  - FlushM = MulStall (inserts a bubble behind the held multiply).
- Flush outputs:
  - FlushD = (PCWrPendingF | PCSrcW | BranchTakenE) & ~StallD.
  - FlushE = (LdrStall | BranchTakenE) & ~StallE.
- Precedence: a stall dominates a flush in the same stage. While MulStall is high, LdrStall still holds D/F. BranchTakenE cannot coincide with MUL because E holds the multiply; if it does, StallE wins.
- Reset mid-multiply: the FSM is abandoned immediately. After release, the stalls drop on the first cycle with no pending inputs.

Decomposition:
- Package tessiax_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - mul_state_t enum (IDLE, MUL).
  - Constants ALU_MUL=4'b0010 and REG_PC=4'hF.
- One sub-module, mul_sequencer: holds the FSM and Cnt. Outputs MulStall, MulBusy and MulDoneE; parameter MUL_CYCLES.
- Forwarding, load-use and flush logic stay in the top module.

Test Plan:
- Forwarding priority: RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. RA1E=WA3M=15 -> ForwardAE=00.
- Load-use: MemToRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle, StallE=0. Change RA2D to 6 -> all deasserted.
- Multiply, MUL_CYCLES=4: MulStartE high at cycle 0 -> StallE=FlushM=1 at cycles 0-2 and MulBusy=1 at cycles 1-3. At cycle 3: MulDoneE=1 and StallE=0. Cycle 4: back in IDLE.
- Multiply with MUL_CYCLES=1: MulStartE=1 -> MulDoneE=1, no stall, MulBusy stays 0.
- Branch: BranchTakenE=1 in IDLE -> FlushD=FlushE=1, StallE=0. Same input during MUL -> FlushE=0, StallE=1.
- Async reset at cycle 1 of a 4-cycle multiply -> MulBusy=0 and StallE=0 immediately without a clock edge. After release, MulStartE=0 -> all stalls stay 0.
